sram_line_controller: RTL and testbench

- Responder end of the shared SRAM request interface, i.e. the side that receives read_enable, write_enable, address and write_data after fill/alpha arbitration.
- Converts one 1536-bit line request into a 48-beat burst of 32-bit accesses on the physical single-port SRAM.
- Returns the assembled read line with a one-cycle data_ready pulse, and asserts busy while a burst is in flight.

---
 rtl/sram_line_controller_if.sv | 55 +++++
 rtl/sram_line_controller.sv | 186 ++++++++++++++++++
 tb/tb_sram_line_controller.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/sram_line_controller_if.sv
// ----------------------------------------------------------------------------
// sram_line_controller_if
//
// Line-level request/response bundle between the fill/alpha arbiter and
// the SRAM line controller.
//
//   read_enable   requester -> responder  line read request (level)
//   write_enable  requester -> responder  line write request (level)
//   address       requester -> responder  line address
//   write_data    requester -> responder  line write data
//   read_data     responder -> requester  assembled read line
//   data_ready    responder -> requester  one-cycle completion pulse
//   busy          responder -> requester  burst in flight, requests ignored
//   protocol_err  responder -> requester  both enables seen at acceptance
//
// The master modport is the arbiter side. The slave modport is the
// controller side.
// ----------------------------------------------------------------------------
interface sram_line_controller_if #(
    parameter int ADDR_W = 19,
    parameter int LINE_W = 1536
) ();

    logic              read_enable;
    logic              write_enable;
    logic [ADDR_W-1:0] address;
    logic [LINE_W-1:0] write_data;
    logic [LINE_W-1:0] read_data;
    logic              data_ready;
    logic              busy;
    logic              protocol_err;

    modport master (
        output read_enable,
        output write_enable,
        output address,
        output write_data,
        input  read_data,
        input  data_ready,
        input  busy,
        input  protocol_err
    );

    modport slave (
        input  read_enable,
        input  write_enable,
        input  address,
        input  write_data,
        output read_data,
        output data_ready,
        output busy,
        output protocol_err
    );

endinterface

// File: rtl/sram_line_controller.sv
// ----------------------------------------------------------------------------
// sram_line_controller
//
// Converts one line request into a burst of BEATS word accesses on a
// single-port SRAM. The controller returns the assembled read line together
// with a one-cycle data_ready pulse.
//
// Ports
//   clk        system clock
//   n_rst      asynchronous active-low reset
//   bus        line request interface (slave modport)
//   mem_addr   physical word address = {line address, beat}
//   mem_wdata  physical write word (0 when no write strobe)
//   mem_we     physical write strobe
//   mem_re     physical read strobe
//   mem_rdata  physical read word, valid RD_LAT cycles after mem_re
// ----------------------------------------------------------------------------
module sram_line_controller #(
    parameter int ADDR_W = 19,
    parameter int LINE_W = 1536,
    parameter int WORD_W = 32,
    parameter int BEATS  = 48,
    parameter int RD_LAT = 2
) (
    input  logic                  clk,
    input  logic                  n_rst,
    sram_line_controller_if.slave bus,
    output logic [ADDR_W+5:0]     mem_addr,
    output logic [WORD_W-1:0]     mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [WORD_W-1:0]     mem_rdata
);

    localparam int               BEAT_W     = 6;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [2:0]       LAST_DRAIN = 3'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [BEAT_W-1:0] beat;
    logic [2:0]        drain;
    logic              armed;
    logic              proto_err;
    logic              accept;
    logic              beat_last;
    logic              drain_last;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] rdata_q;

    // Read-return tracking: index k holds what was issued k+1 cycles ago.
    logic              rd_vld_p  [RD_LAT];
    logic [BEAT_W-1:0] rd_beat_p [RD_LAT];

    // A request is taken only after both enables have been seen low in IDLE.
    // This prevents a held level from starting a second burst.
    assign accept     = (state == S_IDLE) && armed &&
                        (bus.read_enable || bus.write_enable);
    assign beat_last  = (beat == LAST_BEAT);
    assign drain_last = (drain == LAST_DRAIN);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                // Write wins when both enables are high.
                if (accept) begin
                    state_nxt = bus.write_enable ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                if (beat_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_READ: begin
                if (beat_last) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Control state: counters, arming, error pulse, read-return valids.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            beat      <= '0;
            drain     <= '0;
            armed     <= 1'b0;
            proto_err <= 1'b0;
            for (int k = 0; k < RD_LAT; k++) begin
                rd_vld_p[k] <= 1'b0;
            end
        end else begin
            if (state == S_WRITE || state == S_READ) begin
                beat <= beat_last ? '0 : beat + 1'b1;
            end
            if (state == S_DRAIN) begin
                drain <= drain_last ? '0 : drain + 1'b1;
            end
            if (state == S_IDLE) begin
                if (accept) begin
                    armed <= 1'b0;
                end else if (!bus.read_enable && !bus.write_enable) begin
                    armed <= 1'b1;
                end
            end
            proto_err   <= accept && bus.read_enable && bus.write_enable;
            rd_vld_p[0] <= mem_re;
            for (int k = 1; k < RD_LAT; k++) begin
                rd_vld_p[k] <= rd_vld_p[k-1];
            end
        end
    end

    // Request capture and beat-index delay line (data only, no reset).
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= bus.address;
            wdata_q <= bus.write_data;
        end
        rd_beat_p[0] <= beat;
        for (int k = 1; k < RD_LAT; k++) begin
            rd_beat_p[k] <= rd_beat_p[k-1];
        end
    end

    // Read line assembly. The line is held after the burst and is only
    // overwritten by the returns of the next read.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rdata_q <= '0;
        end else if (rd_vld_p[RD_LAT-1]) begin
            rdata_q[int'(rd_beat_p[RD_LAT-1]) * WORD_W +: WORD_W] <= mem_rdata;
        end
    end

    // Physical strobes come straight from state. Address and data are
    // forced to 0 whenever no strobe is active.
    always_comb begin
        mem_we    = (state == S_WRITE);
        mem_re    = (state == S_READ);
        mem_addr  = '0;
        mem_wdata = '0;
        if (mem_we || mem_re) begin
            mem_addr = {addr_q, beat};
        end
        if (mem_we) begin
            mem_wdata = wdata_q[int'(beat) * WORD_W +: WORD_W];
        end
    end

    assign bus.read_data    = rdata_q;
    assign bus.data_ready   = (state == S_DONE);
    assign bus.busy         = (state != S_IDLE);
    assign bus.protocol_err = proto_err;

endmodule

// File: tb/tb_sram_line_controller.sv
// ----------------------------------------------------------------------------
// tb_sram_line_controller
//
// Directed and randomized bench for sram_line_controller. It contains a
// behavioural SRAM with RD_LAT read latency and a line-level shadow memory
// that holds the expected contents.
// ----------------------------------------------------------------------------
module tb_sram_line_controller;

    parameter int RD_LAT = 2;
    localparam int ADDR_W = 19;
    localparam int LINE_W = 1536;
    localparam int WORD_W = 32;
    localparam int BEATS  = 48;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    sram_line_controller_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    logic [ADDR_W+5:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_we;
    logic              mem_re;

    sram_line_controller #(
        .ADDR_W(ADDR_W), .LINE_W(LINE_W), .WORD_W(WORD_W),
        .BEATS(BEATS), .RD_LAT(RD_LAT)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .bus       (bus.slave),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
    );

    // The SRAM model stores 16 line slots and indexes them by the low address nibble.
    logic        preload;
    logic [31:0] sram_mem [1024];
    logic        rp_vld   [RD_LAT];
    logic [31:0] rp_data  [RD_LAT];
    logic [31:0] junk;

    function automatic logic [31:0] init_word(input int idx);
        return 32'hC0DE_0000 ^ 32'(idx);
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) sram_mem[i] <= init_word(i);
        end else if (mem_we) begin
            sram_mem[mem_addr[9:0]] <= mem_wdata;
        end
        rp_vld[0]  <= mem_re;
        rp_data[0] <= sram_mem[mem_addr[9:0]];
        for (int k = 1; k < RD_LAT; k++) begin
            rp_vld[k]  <= rp_vld[k-1];
            rp_data[k] <= rp_data[k-1];
        end
        junk <= $urandom;
    end

    assign mem_rdata = rp_vld[RD_LAT-1] ? rp_data[RD_LAT-1] : junk;

    // The shadow memory holds the expected line for each slot.
    logic [LINE_W-1:0] shadow [16];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // The caller enters this task at the negedge of an armed IDLE cycle (cycle 0).
    // The task returns at the negedge of the next armed IDLE cycle.
    task automatic run_txn(input logic re, input logic we, input logic [ADDR_W-1:0] a,
                           input logic [LINE_W-1:0] d, input int swap_at, input int hold_after);
        logic is_wr;
        int   total;
        is_wr = we;
        total = is_wr ? BEATS + 1 : BEATS + 1 + RD_LAT;
        chk("idle_busy", bus.busy, 0);
        bus.address      = a;
        bus.write_data   = d;
        bus.read_enable  = re;
        bus.write_enable = we;
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.address    = ADDR_W'($urandom);
                bus.write_data = ~d;
            end
            if (k == swap_at) begin
                bus.write_enable = 1'b0;
                bus.read_enable  = 1'b1;
            end
            if (k <= BEATS) begin
                chk("mem_we", mem_we, is_wr);
                chk("mem_re", mem_re, !is_wr);
                chk("mem_addr", mem_addr, {a, 6'(k-1)});
                chk("mem_wdata", mem_wdata, is_wr ? d[(k-1)*32 +: 32] : 32'd0);
            end else begin
                chk("tail_we", mem_we, 0);
                chk("tail_re", mem_re, 0);
                chk("tail_addr", mem_addr, 0);
                chk("tail_wdata", mem_wdata, 0);
            end
            chk("busy", bus.busy, 1);
            chk("data_ready", bus.data_ready, (k == total));
            chk("protocol_err", bus.protocol_err, (k == 1) && re && we);
        end
        if (is_wr) begin
            shadow[a[3:0]] = d;
        end else begin
            for (int i = 0; i < BEATS; i++)
                chk("read_word", bus.read_data[i*32 +: 32], shadow[a[3:0]][i*32 +: 32]);
        end
        for (int h = 0; h < hold_after; h++) begin
            @(negedge clk);
            chk("held_busy", bus.busy, 0);
            chk("held_mem_re", mem_re, 0);
        end
        @(negedge clk);
        chk("end_busy", bus.busy, 0);
        chk("end_data_ready", bus.data_ready, 0);
        if (!is_wr) chk("rdata_held", (bus.read_data === shadow[a[3:0]]), 1);
        bus.read_enable  = 1'b0;
        bus.write_enable = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int i = 0; i < BEATS; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    initial begin
        logic [LINE_W-1:0] line;
        int dr_cnt;
        int re_cnt;

        for (int s = 0; s < 16; s++)
            for (int i = 0; i < BEATS; i++)
                shadow[s][i*32 +: 32] = init_word(s * 64 + i);

        n_rst            = 1'b0;
        preload          = 1'b1;
        bus.read_enable  = 1'b0;
        bus.write_enable = 1'b0;
        bus.address      = '0;
        bus.write_data   = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_data_ready", bus.data_ready, 0);
        chk("rst_protocol_err", bus.protocol_err, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_read_data", (bus.read_data === '0), 1);
        preload = 1'b0;
        n_rst   = 1'b1;
        @(negedge clk);

        // Write line 0x00005, then read it back.
        for (int i = 0; i < BEATS; i++) line[i*32 +: 32] = 32'hA500_0000 + 32'(i);
        run_txn(1'b0, 1'b1, 19'h00005, line, 0, 0);
        run_txn(1'b1, 1'b0, 19'h00005, '0, 0, 0);

        // Both enables high: the write is done and protocol_err pulses.
        run_txn(1'b1, 1'b1, 19'h00006, rand_line(), 0, 0);
        run_txn(1'b1, 1'b0, 19'h00006, '0, 0, 0);

        // A read request during a write is ignored and is not taken until re-armed.
        run_txn(1'b0, 1'b1, 19'h00008, rand_line(), 10, 5);
        run_txn(1'b1, 1'b0, 19'h00008, '0, 0, 0);

        // A held read enable gives exactly one burst.
        bus.address     = 19'h00009;
        bus.read_enable = 1'b1;
        dr_cnt = 0;
        re_cnt = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            dr_cnt += int'(bus.data_ready);
            re_cnt += int'(mem_re);
        end
        chk("held_data_ready_count", dr_cnt, 1);
        chk("held_mem_re_count", re_cnt, BEATS);
        chk("held_read_line", (bus.read_data === shadow[9]), 1);
        bus.read_enable = 1'b0;
        @(negedge clk);
        run_txn(1'b1, 1'b0, 19'h00009, '0, 0, 0);

        // Reset during a read, then hold the enable across reset release.
        bus.address     = 19'h00007;
        bus.read_enable = 1'b1;
        repeat (20) @(negedge clk);
        chk("mid_read_mem_re", mem_re, 1);
        n_rst = 1'b0;
        #1;
        chk("async_rst_mem_re", mem_re, 0);
        chk("async_rst_busy", bus.busy, 0);
        chk("async_rst_read_data", (bus.read_data === '0), 1);
        @(negedge clk);
        n_rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("post_rst_busy", bus.busy, 0);
        end
        bus.read_enable = 1'b0;
        @(negedge clk);
        run_txn(1'b1, 1'b0, 19'h00007, '0, 0, 0);

        // Randomized mix of writes, reads and simultaneous requests.
        for (int t = 0; t < 10; t++) begin
            int op;
            logic [ADDR_W-1:0] a;
            op = $urandom_range(0, 2);
            a  = {15'($urandom), 4'($urandom_range(0, 15))};
            run_txn(op != 0, op != 1, a, rand_line(), 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
